rr_arbiter_8: RTL

Eight-way round-robin arbiter that shares a single resource between requesters 0..7. Internally it tracks the winner as a 3-bit index and drives a one-hot 3-to-8 decoded grant vector. Each winner keeps the grant until it drops its request or exceeds a configurable hold limit. The block sits in front of any shared datapath in the design that needs fair, starvation-free access by eight clients.

---
 rtl/rr_arbiter_8.sv | 109 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with per-win hold limit and timeout ban.
// Winner kept as a 3-bit index; grant vector is its registered one-hot decode.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N_REQ    = 8;
  localparam logic [7:0]  HOLD_LIM = 8'(MAX_HOLD);
  localparam logic        HOLD_EN  = (MAX_HOLD != 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_ban;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_valid;
  logic       r_timeout;

  logic [7:0] w_elig;
  logic [2:0] w_idx;
  logic [2:0] w_win;
  logic       w_found;
  logic       w_req_cur;
  logic       w_hold_hit;

  // Circular first-set scan of eligible requesters starting at r_ptr
  always_comb begin
    w_elig  = req & ~r_ban;
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = 3'(r_ptr + 3'(i));
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_req_cur  = req[r_gnt_idx];
    w_hold_hit = HOLD_EN && (r_hold_cnt == HOLD_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 3'd0;
      r_hold_cnt  <= 8'd0;
      r_ban       <= 8'd0;
      r_gnt       <= 8'd0;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A ban lifts once its requester has been seen idle
      r_ban     <= r_ban & req;
      case (r_state)
        ST_IDLE: begin
          if (en && w_found) begin
            r_gnt_idx   <= w_win;
            r_gnt       <= 8'(1) << w_win;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= 8'd1;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_req_cur) begin
            r_gnt_valid <= 1'b0;
            r_gnt       <= 8'd0;
            r_ptr       <= 3'(r_gnt_idx + 3'd1);
            r_state     <= ST_IDLE;
          end else if (w_hold_hit) begin
            r_gnt_valid <= 1'b0;
            r_gnt       <= 8'd0;
            r_timeout   <= 1'b1;
            r_ban       <= (r_ban & req) | (8'(1) << r_gnt_idx);
            r_ptr       <= 3'(r_gnt_idx + 3'd1);
            r_state     <= ST_IDLE;
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
